bus_trace_buffer: RTL and testbench
===================================

Name: bus_trace_buffer

Overview:
- Synthesisable on-chip logic analyser for the B32P CPU memory bus.
- Captures bus accesses into a circular buffer of parametrised depth and width, with an address-match trigger and a programmable number of post-trigger samples.
- After capture, a readback port returns entries oldest-first.
- Placed beside the CPU in simulation and hardware builds, so bus activity is observable without dumping full waveforms.

Parameters:
- DATA_W, 32: bus data width.
- ADDR_W, 27: bus address width.
- DEPTH, 64: buffer entries; power of two, >= 4.
- POST_TRIG, 32: entries captured after the trigger entry; 0 .. DEPTH-1.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset.
- arm  in  1  single-cycle pulse; starts a capture.
- abort  in  1  single-cycle pulse; cancels a capture.
- trig_addr  in  ADDR_W  trigger compare address.
- trig_mask  in  ADDR_W  address bits that take part in the compare (1 = compare).
- bus_valid  in  1  a bus access completes this cycle.
- bus_we  in  1  access is a write.
- bus_addr  in  ADDR_W  access address.
- bus_data  in  DATA_W  write data or read data.
- rd_idx  in  log2(DEPTH)  readback index; 0 = oldest entry.
- rd_we  out  1  readback: we bit.
- rd_addr  out  ADDR_W  readback: address.
- rd_data  out  DATA_W  readback: data.
- state  out  2  0 IDLE, 1 PRE, 2 POST, 3 DONE.
- count  out  log2(DEPTH)+1  valid entries, 0..DEPTH.
- trig_idx  out  log2(DEPTH)  position of the trigger entry relative to the oldest entry.
- done  out  1  high in DONE.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - Write pointer, count, trig_idx, post counter, rd_* and done all go to 0.
  - Buffer contents are undefined.
  - Reset mid-capture discards the capture.
- IDLE, DONE:
  - No writes.
  - arm=1: clear write pointer, count and trig_idx; go to PRE next cycle.
- PRE:
  - Each cycle with bus_valid=1 writes {bus_we, bus_addr, bus_data} at the write pointer.
  - Write pointer increments modulo DEPTH; count saturates at DEPTH.
  - Trigger condition: bus_valid && (((bus_addr ^ trig_addr) & trig_mask) == 0).
  - On trigger: the triggering access is written, the post counter loads POST_TRIG, and state goes to POST. If POST_TRIG=0, state goes straight to DONE.
  - A trigger is evaluated only in PRE.
- POST:
  - Each bus_valid write decrements the post counter.
  - The write that brings it to 0 is stored, and the state goes to DONE the same edge.
- trig_idx:
  - Always presented relative to the oldest entry: (trigger slot − oldest slot) mod DEPTH.
  - Updated as the buffer wraps so it stays correct once capture completes.
  - In DONE with a full buffer, trig_idx = DEPTH−1−POST_TRIG.
- abort:
  - In any state, goes to IDLE next cycle and keeps count and buffer contents.
  - abort and arm in the same cycle: abort wins.
  - arm in PRE or POST is ignored.
- Readback:
  - Available in every state.
  - rd_* is registered, 1-cycle latency from rd_idx.
  - Physical slot = (wr_ptr − count + rd_idx) mod DEPTH.
  - rd_idx >= count returns all zeros.
  - Reads during active capture reflect the pre-edge pointer.
- done = (state == DONE).
- The buffer is inferrable as block RAM: one write port and one registered read port.

Optional Feature:
- Macro: TRACE_TIMESTAMP_EN.
- Defined:
  - A 16-bit free-running cycle counter is cleared on arm and wraps at 0xFFFF.
  - The counter value is stored with each entry.
  - An extra output port rd_ts (16 bits) follows the same 1-cycle readback latency; reset value 0.
- Undefined:
  - No counter and no rd_ts port.
  - Entry width is 1+ADDR_W+DATA_W.

Test Plan (DEPTH=8, POST_TRIG=3 unless stated):
- Reset then release; no stimulus -> state=0, count=0, done=0, rd_addr=0, rd_data=0.
- arm; accesses to 0x10..0x15 with data 0xA0..0xA5; trig_addr=0x12, mask all ones:
  - state=POST after 0x12.
  - DONE after 0x15.
  - count=6, trig_idx=2.
  - rd_idx 0..5 -> 0x10..0x15 and 0xA0..0xA5.
  - rd_idx 6 -> zeros.
- Wrap-around: arm; 20 accesses at 0x20+i, then trigger 0x100, then 0x200..0x202:
  - count=8, trig_idx=4.
  - rd_idx0=0x30, rd_idx4=0x100, rd_idx7=0x202.
- Masked trigger: trig_addr=0x300, trig_mask=0x7FFFF00; accesses 0x2FF, 0x3A4 -> trigger on 0x3A4; 0x2FF does not trigger.
- POST_TRIG=0: trigger access -> DONE on the same edge.
- abort:
  - abort during POST -> IDLE next cycle, done=0, count kept.
  - arm+abort in the same cycle -> IDLE.
- Reset pulse asynchronously mid-POST -> state=0 and count=0 before the next clk edge.

Source files
------------

// File: rtl/bus_trace_buffer.sv
// bus_trace_buffer: on-chip logic analyser for the B32P memory bus.
// Captures bus accesses into a circular buffer with an address-match
// trigger and POST_TRIG post-trigger samples, then reads back oldest-first.
//
// Ports:
//   clk, reset (async, active-low)
//   arm, abort            : capture control pulses
//   trig_addr, trig_mask  : trigger compare (mask bit 1 = compare)
//   bus_valid/we/addr/data: observed bus access
//   rd_idx                : readback index, 0 = oldest
//   rd_we/addr/data(/ts)  : registered readback entry, 1-cycle latency
//   state, count, trig_idx, done : capture status
//
// Optional: define TRACE_TIMESTAMP_EN to store a 16-bit cycle stamp per
// entry and expose it on rd_ts.

module bus_trace_buffer #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 27,
    parameter int DEPTH     = 64,
    parameter int POST_TRIG = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     arm,
    input  logic                     abort,
    input  logic [ADDR_W-1:0]        trig_addr,
    input  logic [ADDR_W-1:0]        trig_mask,
    input  logic                     bus_valid,
    input  logic                     bus_we,
    input  logic [ADDR_W-1:0]        bus_addr,
    input  logic [DATA_W-1:0]        bus_data,
    input  logic [$clog2(DEPTH)-1:0] rd_idx,
    output logic                     rd_we,
    output logic [ADDR_W-1:0]        rd_addr,
    output logic [DATA_W-1:0]        rd_data,
`ifdef TRACE_TIMESTAMP_EN
    output logic [15:0]              rd_ts,
`endif
    output logic [1:0]               state,
    output logic [$clog2(DEPTH):0]   count,
    output logic [$clog2(DEPTH)-1:0] trig_idx,
    output logic                     done
);

    localparam int AW = $clog2(DEPTH);
`ifdef TRACE_TIMESTAMP_EN
    localparam int EW = 1 + ADDR_W + DATA_W + 16;
`else
    localparam int EW = 1 + ADDR_W + DATA_W;
`endif
    localparam logic [AW-1:0] PT   = AW'(POST_TRIG);
    localparam logic [AW:0]   FULL = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PRE  = 2'd1,
        S_POST = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [AW-1:0]   r_wr_ptr;
    logic [AW:0]     r_count;
    logic [AW-1:0]   r_trig_idx;
    logic [AW-1:0]   r_post;
    logic [EW-1:0]   r_mem [DEPTH];
    logic [EW-1:0]   r_rd_q;
    logic            r_rd_vld;

    logic            w_hit;
    logic            w_wr_en;
    logic            w_clear;
    logic            w_full;
    logic [EW-1:0]   w_wdata;
    logic [AW-1:0]   w_rd_slot;
    logic            w_rd_ok;

    assign w_hit  = bus_valid &&
                    (((bus_addr ^ trig_addr) & trig_mask) == '0);
    assign w_full = (r_count == FULL);

`ifdef TRACE_TIMESTAMP_EN
    logic [15:0] r_ts;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)       r_ts <= '0;
        else if (w_clear) r_ts <= '0;
        else              r_ts <= r_ts + 16'd1;
    end

    assign w_wdata = {bus_we, bus_addr, bus_data, r_ts};
`else
    assign w_wdata = {bus_we, bus_addr, bus_data};
`endif

    // Next-state and write/clear strobes
    always_comb begin
        w_state_nxt = r_state;
        w_wr_en     = 1'b0;
        w_clear     = 1'b0;
        if (abort) begin
            w_state_nxt = S_IDLE;
        end else begin
            unique case (r_state)
                S_IDLE, S_DONE: begin
                    if (arm) begin
                        w_clear     = 1'b1;
                        w_state_nxt = S_PRE;
                    end
                end
                S_PRE: begin
                    if (bus_valid) begin
                        w_wr_en = 1'b1;
                        if (w_hit)
                            w_state_nxt = (POST_TRIG == 0) ? S_DONE : S_POST;
                    end
                end
                S_POST: begin
                    if (bus_valid) begin
                        w_wr_en = 1'b1;
                        if (r_post == AW'(1))
                            w_state_nxt = S_DONE;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Pointer, fill count, trigger position and post-trigger counter.
    // trig_idx is kept relative to the oldest entry: once the buffer is
    // full every further write drops the oldest entry, so it moves down.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_trig_idx <= '0;
            r_post     <= '0;
        end else if (w_clear) begin
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_trig_idx <= '0;
        end else if (w_wr_en) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
            if (!w_full)
                r_count <= r_count + (AW+1)'(1);
            if (r_state == S_PRE && w_hit) begin
                r_trig_idx <= w_full ? AW'(DEPTH - 1) : r_count[AW-1:0];
                r_post     <= PT;
            end else if (r_state == S_POST) begin
                r_post <= r_post - AW'(1);
                if (w_full)
                    r_trig_idx <= r_trig_idx - AW'(1);
            end
        end
    end

    // Oldest slot is wr_ptr - count; a full count wraps to 0 in AW bits
    assign w_rd_slot = r_wr_ptr - r_count[AW-1:0] + rd_idx;
    assign w_rd_ok   = ({1'b0, rd_idx} < r_count);

    // Plain write port plus registered read port, RAM-inferrable
    always_ff @(posedge clk) begin
        if (w_wr_en)
            r_mem[r_wr_ptr] <= w_wdata;
        r_rd_q <= r_mem[w_rd_slot];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_rd_vld <= 1'b0;
        else        r_rd_vld <= w_rd_ok;
    end

`ifdef TRACE_TIMESTAMP_EN
    assign {rd_we, rd_addr, rd_data, rd_ts} = r_rd_vld ? r_rd_q : '0;
`else
    assign {rd_we, rd_addr, rd_data} = r_rd_vld ? r_rd_q : '0;
`endif

    assign state    = r_state;
    assign count    = r_count;
    assign trig_idx = r_trig_idx;
    assign done     = (r_state == S_DONE);

endmodule

// File: tb/tb_bus_trace_buffer.sv
// tb_bus_trace_buffer: randomized scoreboard bench for bus_trace_buffer
// with a queue-based trace model (DEPTH=8, POST_TRIG=3 and POST_TRIG=0).

module tb_bus_trace_buffer;

    localparam int DW = 32;
    localparam int AWD = 27;
    localparam int D = 8;
    localparam int PT = 3;
    localparam int IW = 3;
    localparam int EW = 1 + AWD + DW;

    typedef logic [EW-1:0] ent_t;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           arm = 1'b0;
    logic           abort = 1'b0;
    logic [AWD-1:0] trig_addr = '0;
    logic [AWD-1:0] trig_mask = '0;
    logic           bus_valid = 1'b0;
    logic           bus_we = 1'b0;
    logic [AWD-1:0] bus_addr = '0;
    logic [DW-1:0]  bus_data = '0;
    logic [IW-1:0]  rd_idx = '0;

    logic           rd_we;
    logic [AWD-1:0] rd_addr;
    logic [DW-1:0]  rd_data;
    logic [1:0]     state;
    logic [IW:0]    count;
    logic [IW-1:0]  trig_idx;
    logic           done;

    logic           z_rd_we;
    logic [AWD-1:0] z_rd_addr;
    logic [DW-1:0]  z_rd_data;
    logic [1:0]     z_state;
    logic [IW:0]    z_count;
    logic [IW-1:0]  z_trig_idx;
    logic           z_done;

    always #5 clk = ~clk;

    bus_trace_buffer #(
        .DATA_W(DW), .ADDR_W(AWD), .DEPTH(D), .POST_TRIG(PT)
    ) dut (
        .clk(clk), .reset(reset), .arm(arm), .abort(abort),
        .trig_addr(trig_addr), .trig_mask(trig_mask),
        .bus_valid(bus_valid), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_data(bus_data),
        .rd_idx(rd_idx), .rd_we(rd_we), .rd_addr(rd_addr),
        .rd_data(rd_data), .state(state), .count(count),
        .trig_idx(trig_idx), .done(done)
    );

    bus_trace_buffer #(
        .DATA_W(DW), .ADDR_W(AWD), .DEPTH(D), .POST_TRIG(0)
    ) dut0 (
        .clk(clk), .reset(reset), .arm(arm), .abort(abort),
        .trig_addr(trig_addr), .trig_mask(trig_mask),
        .bus_valid(bus_valid), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_data(bus_data),
        .rd_idx(rd_idx), .rd_we(z_rd_we), .rd_addr(z_rd_addr),
        .rd_data(z_rd_data), .state(z_state), .count(z_count),
        .trig_idx(z_trig_idx), .done(z_done)
    );

    int n_chk = 0;
    int n_fail = 0;

    // Trace model: the captured accesses, oldest first
    ent_t mq[$];
    int   m_total = 0;
    int   m_trig = 0;
    int   m_phase = 0;
    int   m_post = 0;

    ent_t exp_q[$];
    logic rd_req = 1'b0;
    logic req_d = 1'b0;

    task automatic check(input string nm, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    always @(posedge clk) req_d <= rd_req;

    always @(negedge clk) begin : mon
        ent_t e;
        if (req_d) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL readback: got output with empty queue");
            end else begin
                e = exp_q.pop_front();
                check("readback", 64'({rd_we, rd_addr, rd_data}), 64'(e));
            end
        end
    end

    function automatic bit hit(input logic [AWD-1:0] a);
        return ((a ^ trig_addr) & trig_mask) == '0;
    endfunction

    task automatic bus(input logic we, input logic [AWD-1:0] a,
                       input logic [DW-1:0] d);
        @(negedge clk);
        bus_valid = 1'b1;
        bus_we = we;
        bus_addr = a;
        bus_data = d;
        if (m_phase == 1 || m_phase == 2) begin
            mq.push_back({we, a, d});
            if (mq.size() > D) void'(mq.pop_front());
            m_total++;
            if (m_phase == 1 && hit(a)) begin
                m_trig = m_total - 1;
                m_post = PT;
                m_phase = (PT == 0) ? 3 : 2;
            end else if (m_phase == 2) begin
                m_post--;
                if (m_post == 0) m_phase = 3;
            end
        end
        @(posedge clk);
        #1 bus_valid = 1'b0;
    endtask

    task automatic idle();
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic do_arm();
        @(negedge clk);
        arm = 1'b1;
        if (m_phase == 0 || m_phase == 3) begin
            mq.delete();
            m_total = 0;
            m_trig = 0;
            m_phase = 1;
        end
        @(posedge clk);
        #1 arm = 1'b0;
    endtask

    task automatic do_abort(input logic with_arm);
        @(negedge clk);
        abort = 1'b1;
        arm = with_arm;
        m_phase = 0;
        @(posedge clk);
        #1;
        abort = 1'b0;
        arm = 1'b0;
    endtask

    task automatic rd(input int i);
        @(negedge clk);
        rd_idx = IW'(i);
        rd_req = 1'b1;
        exp_q.push_back((i < mq.size()) ? mq[i] : '0);
        @(posedge clk);
        #1 rd_req = 1'b0;
    endtask

    task automatic read_all();
        for (int i = 0; i < D; i++) rd(i);
    endtask

    task automatic status();
        @(negedge clk);
        check("state", 64'(state), 64'(m_phase));
        check("done", 64'(done), 64'(m_phase == 3));
        check("count", 64'(count), 64'(mq.size()));
        if (m_phase >= 2)
            check("trig_idx", 64'(trig_idx),
                  64'(m_trig - (m_total - mq.size())));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rst_state", 64'(state), 64'd0);
        check("rst_count", 64'(count), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_rd_addr", 64'(rd_addr), 64'd0);
        check("rst_rd_data", 64'(rd_data), 64'd0);

        // Basic capture, exact trigger
        trig_addr = 27'h12;
        trig_mask = 27'h7FFFFFF;
        do_arm();
        bus(1'b1, 27'h10, 32'hA0);
        bus(1'b0, 27'h11, 32'hA1);
        @(negedge clk);
        check("pt0_pre", 64'(z_state), 64'd1);
        bus(1'b1, 27'h12, 32'hA2);
        status();
        check("pt0_done", 64'(z_state), 64'd3);
        check("pt0_done_o", 64'(z_done), 64'd1);
        check("pt0_count", 64'(z_count), 64'd3);
        bus(1'b0, 27'h13, 32'hA3);
        bus(1'b1, 27'h14, 32'hA4);
        status();
        bus(1'b0, 27'h15, 32'hA5);
        status();
        check("basic_trig_idx", 64'(trig_idx), 64'd2);
        read_all();

        // Wrap-around
        trig_addr = 27'h100;
        do_arm();
        for (int i = 0; i < 20; i++)
            bus(i[0], 27'(32'h20 + i), $urandom);
        bus(1'b0, 27'h100, $urandom);
        status();
        for (int i = 0; i < 3; i++)
            bus(1'b1, 27'(32'h200 + i), $urandom);
        status();
        check("wrap_trig_idx", 64'(trig_idx), 64'd4);
        read_all();

        // Masked trigger, then abort in POST
        trig_addr = 27'h300;
        trig_mask = 27'h7FFFF00;
        do_arm();
        bus(1'b0, 27'h2FF, 32'h1111);
        status();
        bus(1'b1, 27'h3A4, 32'h2222);
        status();
        do_abort(1'b0);
        status();
        do_abort(1'b1);
        status();
        rd(0);
        rd(1);
        rd(2);

        // Asynchronous reset mid-POST
        trig_addr = 27'h12;
        trig_mask = 27'h7FFFFFF;
        do_arm();
        bus(1'b0, 27'h12, 32'h5);
        status();
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("arst_state", 64'(state), 64'd0);
        check("arst_count", 64'(count), 64'd0);
        check("arst_done", 64'(done), 64'd0);
        #1 reset = 1'b1;
        mq.delete();
        m_total = 0;
        m_trig = 0;
        m_phase = 0;
        status();

        // Randomized captures
        for (int r = 0; r < 6; r++) begin
            trig_addr = 27'($urandom_range(0, 31));
            trig_mask = {22'h3FFFFF, 5'($urandom)};
            do_arm();
            for (int k = 0; k < 40 && m_phase != 3; k++) begin
                if ($urandom_range(0, 3) == 0)
                    idle();
                else
                    bus(1'($urandom), 27'($urandom_range(0, 31)), $urandom);
            end
            status();
            read_all();
            do_abort(1'b0);
            status();
        end

        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
